// File: rtl/dec_scan_n_pkg.sv
// Shared mode and sequencer-state encodings for the scanning one-hot decoder.
package dec_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/dec_scan_n_if.sv
// Control and output bundle of dec_scan_n; the slave side is the decoder.
interface dec_scan_n_if #(
  parameter int unsigned SEL_W = 4
);
  localparam int unsigned N = 1 << SEL_W;

  logic             En;
  logic [1:0]       Mode;
  logic [SEL_W-1:0] W;
  logic             Start;
  logic [0:N-1]     Y;
  logic [SEL_W-1:0] Idx;
  logic             Busy;
  logic             Done;

  modport master (output En, Mode, W, Start, input Y, Idx, Busy, Done);
  modport slave  (input En, Mode, W, Start, output Y, Idx, Busy, Done);
endinterface

// File: rtl/dec_scan_n_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable; y[0] is index 0.
module dec_onehot #(
  parameter int unsigned SEL_W = 4
) (
  input  logic                   en,
  input  logic [SEL_W-1:0]       sel,
  output logic [0:(1<<SEL_W)-1]  y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_scan_n.sv
// Registered one-hot decoder with direct, continuous-scan, single-sweep and hold modes.
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DWELL = 4,
  parameter int unsigned LAST  = (1 << SEL_W) - 1
) (
  input logic         Clock,
  input logic         Resetn,
  dec_scan_n_if.slave bus
);

  localparam int unsigned N     = 1 << SEL_W;
  localparam int unsigned CNT_W = $clog2(DWELL + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(DWELL - 1);

  logic [0:N-1]     y_q, y_d, dec_y;
  logic [SEL_W-1:0] idx_q, idx_d, adv_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d, adv_cnt;
  logic             busy_q, busy_d, done_q, done_d;
  logic             dec_en, hold_y, dwell_end, mode_entry;
  state_e           state_q, state_d;
  mode_e            mode_q, mode_in;

  assign mode_in    = mode_e'(bus.Mode);
  assign mode_entry = (mode_in != mode_q);
  assign dwell_end  = (cnt_q == CNT_END);
  assign adv_cnt    = dwell_end ? '0 : cnt_q + CNT_W'(1);
  assign adv_idx    = !dwell_end ? idx_q :
                      (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    state_d = state_q;
    dec_en  = 1'b0;
    hold_y  = 1'b0;
    case (mode_in)
      MODE_DIRECT: begin
        idx_d   = bus.W;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
        dec_en  = bus.En;
      end
      MODE_SCAN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        dec_en  = bus.En;
        if (mode_entry) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (bus.En) begin
          idx_d = adv_idx;
          cnt_d = adv_cnt;
        end
      end
      MODE_SWEEP: begin
        // Entering the mode always lands in IDLE, so a same-cycle Start is dropped.
        if (mode_entry) begin
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (state_q == IDLE) begin
          if (bus.Start && bus.En) begin
            idx_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SWEEP;
            dec_en  = 1'b1;
          end
        end else if (bus.En) begin
          if (dwell_end && idx_q == LAST_IDX) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = adv_idx;
            cnt_d  = adv_cnt;
            dec_en = 1'b1;
          end
        end
      end
      MODE_HOLD: hold_y = 1'b1;
      default: hold_y = 1'b1;
    endcase
  end

  dec_onehot #(.SEL_W(SEL_W)) u_dec (
    .en  (dec_en),
    .sel (idx_d),
    .y   (dec_y)
  );

  assign y_d = hold_y ? y_q : dec_y;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= IDLE;
      mode_q  <= MODE_DIRECT;
    end else begin
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      state_q <= state_d;
      mode_q  <= mode_in;
    end
  end

  assign bus.Y    = y_q;
  assign bus.Idx  = idx_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Scoreboard bench for dec_scan_n: directed vectors push expected outputs, a negedge monitor compares.
module tb_dec_scan_n;

  typedef struct {
    int         dut;
    logic [0:63] y;
    int         idx;
    bit         chk_idx;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  dec_scan_n_if #(.SEL_W(4)) ifa ();
  dec_scan_n_if #(.SEL_W(4)) ifb ();
  dec_scan_n_if #(.SEL_W(4)) ifc ();
  dec_scan_n_if #(.SEL_W(1)) if1 ();
  dec_scan_n_if #(.SEL_W(2)) if2 ();
  dec_scan_n_if #(.SEL_W(6)) if6 ();

  dec_scan_n #(.SEL_W(4), .DWELL(2), .LAST(3)) u_a (.Clock(clk), .Resetn(rst_n), .bus(ifa.slave));
  dec_scan_n #(.SEL_W(4), .DWELL(3), .LAST(3)) u_b (.Clock(clk), .Resetn(rst_n), .bus(ifb.slave));
  dec_scan_n #(.SEL_W(4), .DWELL(1), .LAST(0)) u_c (.Clock(clk), .Resetn(rst_n), .bus(ifc.slave));
  dec_scan_n #(.SEL_W(1)) u_w1 (.Clock(clk), .Resetn(rst_n), .bus(if1.slave));
  dec_scan_n #(.SEL_W(2)) u_w2 (.Clock(clk), .Resetn(rst_n), .bus(if2.slave));
  dec_scan_n #(.SEL_W(6)) u_w6 (.Clock(clk), .Resetn(rst_n), .bus(if6.slave));

  function automatic logic [0:63] oh(int k);
    logic [0:63] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  function automatic exp_t mk(int dut, int yk, int idx, bit chk_idx, logic busy, logic done, string name);
    exp_t e;
    e.dut = dut; e.y = oh(yk); e.idx = idx; e.chk_idx = chk_idx;
    e.busy = busy; e.done = done; e.name = name;
    return e;
  endfunction

  function automatic void compare(exp_t e);
    logic [0:63] ay;
    int          ai;
    logic        ab, ad;
    ay = '0; ai = 0; ab = 1'b0; ad = 1'b0;
    case (e.dut)
      0: begin ay = {ifa.Y, 48'b0}; ai = int'(ifa.Idx); ab = ifa.Busy; ad = ifa.Done; end
      1: begin ay = {ifb.Y, 48'b0}; ai = int'(ifb.Idx); ab = ifb.Busy; ad = ifb.Done; end
      2: begin ay = {ifc.Y, 48'b0}; ai = int'(ifc.Idx); ab = ifc.Busy; ad = ifc.Done; end
      3: begin ay = {if1.Y, 62'b0}; ai = int'(if1.Idx); ab = if1.Busy; ad = if1.Done; end
      4: begin ay = {if2.Y, 60'b0}; ai = int'(if2.Idx); ab = if2.Busy; ad = if2.Done; end
      default: begin ay = if6.Y; ai = int'(if6.Idx); ab = if6.Busy; ad = if6.Done; end
    endcase
    n_tests++;
    if (ay !== e.y || ab !== e.busy || ad !== e.done || (e.chk_idx && ai != e.idx)) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got Y=%h Idx=%0d Busy=%b Done=%b, want Y=%h Idx=%0d Busy=%b Done=%b",
               e.name, e.dut, ay, ai, ab, ad, e.y, e.idx, e.busy, e.done);
    end
  endfunction

  task automatic set_in(int dut, logic en, logic [1:0] mode, int w, logic start);
    case (dut)
      0: begin ifa.En = en; ifa.Mode = mode; ifa.W = 4'(w); ifa.Start = start; end
      1: begin ifb.En = en; ifb.Mode = mode; ifb.W = 4'(w); ifb.Start = start; end
      2: begin ifc.En = en; ifc.Mode = mode; ifc.W = 4'(w); ifc.Start = start; end
      3: begin if1.En = en; if1.Mode = mode; if1.W = 1'(w); if1.Start = start; end
      4: begin if2.En = en; if2.Mode = mode; if2.W = 2'(w); if2.Start = start; end
      default: begin if6.En = en; if6.Mode = mode; if6.W = 6'(w); if6.Start = start; end
    endcase
  endtask

  task automatic cyc(int dut, logic en, logic [1:0] mode, int w, logic start);
    set_in(dut, en, mode, w, start);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) compare(sbq.pop_front());
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int sidx[20] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,2,2,2,3,3,0};
    logic en;
    int w, sw;

    for (int d = 0; d < 6; d++) set_in(d, 1'b0, 2'b00, 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare(mk(0, -1, 0, 1, 1'b0, 1'b0, "reset_a"));
    compare(mk(5, -1, 0, 1, 1'b0, 1'b0, "reset_w6"));
    rst_n = 1'b1;

    // direct decode and async reset
    cyc(0, 1'b1, 2'b00, 5, 1'b0); sbq.push_back(mk(0, 5, 5, 1, 1'b0, 1'b0, "dir_w5"));
    cyc(0, 1'b0, 2'b00, 5, 1'b0); sbq.push_back(mk(0, -1, 5, 1, 1'b0, 1'b0, "dir_en0"));
    cyc(0, 1'b1, 2'b00, 7, 1'b0); sbq.push_back(mk(0, 7, 7, 1, 1'b0, 1'b0, "dir_w7"));
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    compare(mk(0, -1, 0, 1, 1'b0, 1'b0, "async_rst"));
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.push_back(mk(0, -1, 0, 1, 1'b0, 1'b0, "rst_held"));

    // continuous scan with pause
    for (int i = 0; i < 20; i++) begin
      en = !(i >= 13 && i <= 15);
      cyc(0, en, 2'b01, 0, 1'b0);
      sbq.push_back(mk(0, en ? sidx[i] : -1, sidx[i], 1, 1'b0, 1'b0, "scan"));
    end

    // sweep aborted by mode change at Idx=2
    cyc(0, 1'b1, 2'b10, 0, 1'b0); sbq.push_back(mk(0, -1, 0, 1, 1'b0, 1'b0, "swp_entry"));
    cyc(0, 1'b1, 2'b10, 0, 1'b1); sbq.push_back(mk(0, 0, 0, 1, 1'b1, 1'b0, "swp_s0"));
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 1'b1, 2'b10, 0, 1'b0);
      sbq.push_back(mk(0, k / 2, k / 2, 1, 1'b1, 1'b0, "swp_run"));
    end
    cyc(0, 1'b1, 2'b00, 9, 1'b0); sbq.push_back(mk(0, 9, 9, 1, 1'b0, 1'b0, "abort"));
    repeat (3) begin
      cyc(0, 1'b1, 2'b00, 9, 1'b0); sbq.push_back(mk(0, 9, 9, 1, 1'b0, 1'b0, "abort_no_done"));
    end

    // sweep aborted by reset
    cyc(0, 1'b1, 2'b10, 0, 1'b0); sbq.push_back(mk(0, -1, 0, 1, 1'b0, 1'b0, "rswp_entry"));
    cyc(0, 1'b1, 2'b10, 0, 1'b1); sbq.push_back(mk(0, 0, 0, 1, 1'b1, 1'b0, "rswp_s0"));
    for (int k = 1; k <= 2; k++) begin
      cyc(0, 1'b1, 2'b10, 0, 1'b0);
      sbq.push_back(mk(0, k / 2, k / 2, 1, 1'b1, 1'b0, "rswp_run"));
    end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    compare(mk(0, -1, 0, 1, 1'b0, 1'b0, "rst_mid_sweep"));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      cyc(0, 1'b1, 2'b10, 0, 1'b0); sbq.push_back(mk(0, -1, 0, 1, 1'b0, 1'b0, "rst_no_done"));
    end

    // hold at Idx=7
    cyc(0, 1'b1, 2'b00, 7, 1'b0); sbq.push_back(mk(0, 7, 7, 1, 1'b0, 1'b0, "pre_hold"));
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'b1, 2'b11, i, 1'b0); sbq.push_back(mk(0, 7, 7, 1, 1'b0, 1'b0, "hold"));
    end
    cyc(0, 1'b1, 2'b00, 3, 1'b0); sbq.push_back(mk(0, 3, 3, 1, 1'b0, 1'b0, "hold_exit"));
    set_in(0, 1'b0, 2'b00, 0, 1'b0);

    // full sweep handshake, DWELL=3 LAST=3, repeated Start while busy
    cyc(1, 1'b1, 2'b10, 0, 1'b0); sbq.push_back(mk(1, -1, 0, 1, 1'b0, 1'b0, "b_entry"));
    cyc(1, 1'b1, 2'b10, 0, 1'b1); sbq.push_back(mk(1, 0, 0, 1, 1'b1, 1'b0, "b_s0"));
    for (int k = 1; k <= 13; k++) begin
      cyc(1, 1'b1, 2'b10, 0, (k == 5 || k == 6));
      if (k < 12)       sbq.push_back(mk(1, k / 3, k / 3, 1, 1'b1, 1'b0, "b_busy"));
      else if (k == 12) sbq.push_back(mk(1, -1, 0, 0, 1'b0, 1'b1, "b_done"));
      else              sbq.push_back(mk(1, -1, 0, 0, 1'b0, 1'b0, "b_after"));
    end
    cyc(1, 1'b0, 2'b10, 0, 1'b1); sbq.push_back(mk(1, -1, 0, 0, 1'b0, 1'b0, "b_start_en0"));
    cyc(1, 1'b0, 2'b10, 0, 1'b0); sbq.push_back(mk(1, -1, 0, 0, 1'b0, 1'b0, "b_idle"));
    set_in(1, 1'b0, 2'b00, 0, 1'b0);

    // DWELL=1 LAST=0: W above LAST, one-cycle sweep, constant scan
    cyc(2, 1'b1, 2'b00, 15, 1'b0); sbq.push_back(mk(2, 15, 15, 1, 1'b0, 1'b0, "c_w15"));
    cyc(2, 1'b1, 2'b10, 0, 1'b0);  sbq.push_back(mk(2, -1, 0, 1, 1'b0, 1'b0, "c_entry"));
    cyc(2, 1'b1, 2'b10, 0, 1'b1);  sbq.push_back(mk(2, 0, 0, 1, 1'b1, 1'b0, "c_busy"));
    cyc(2, 1'b1, 2'b10, 0, 1'b0);  sbq.push_back(mk(2, -1, 0, 0, 1'b0, 1'b1, "c_done"));
    cyc(2, 1'b1, 2'b10, 0, 1'b0);  sbq.push_back(mk(2, -1, 0, 0, 1'b0, 1'b0, "c_after"));
    repeat (4) begin
      cyc(2, 1'b1, 2'b01, 0, 1'b0); sbq.push_back(mk(2, 0, 0, 1, 1'b0, 1'b0, "c_scan"));
    end
    set_in(2, 1'b0, 2'b00, 0, 1'b0);

    // width variants, random direct selects
    for (int d = 3; d < 6; d++) begin
      sw = (d == 3) ? 1 : (d == 4) ? 2 : 6;
      for (int i = 0; i < 20; i++) begin
        w  = int'($urandom_range((1 << sw) - 1, 0));
        en = (i % 5 != 4);
        cyc(d, en, 2'b00, w, 1'b0);
        sbq.push_back(mk(d, en ? w : -1, w, 1, 1'b0, 1'b0, "width"));
      end
      set_in(d, 1'b0, 2'b00, 0, 1'b0);
    end

    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
